muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide sequencer for the MIPS core that owns the HI/LO register pair. It executes MULT, MULTU, DIV and DIVU as multi-cycle radix-2 operations, and services MTHI/MTLO writes. It sits beside the ALU in the EX stage. It raises `busy` so the hazard unit stalls MFHI/MFLO and any new mul/div until the result is committed.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch the operation in `op` this cycle.
- `op`  in  2  `muldiv_op_t`: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `a`  in  WIDTH  rs operand: multiplicand or dividend.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `flush`  in  1  abort any in-flight operation.
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight; the pipeline stalls on it.
- `done`  out  1  one-cycle pulse after HI/LO commit.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- FSM states: IDLE, RUN, FIX.
- IDLE:
  - `start` with no `flush` latches operand magnitudes, sign flags and the op, clears the 5-bit counter, then goes to RUN.
  - `start` with `flush` in the same cycle: start is ignored.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After 32 steps (counter == 31) the FSM goes to FIX.
- FIX applies sign correction for signed ops, writes HI/LO, then goes to IDLE.
  - Product is negated if the operand signs differ. HI holds the upper half, LO the lower half.
  - Quotient goes to LO and is negated if signs differ. Remainder goes to HI and takes the sign of the dividend.
- Divide by zero (b == 0), any signedness: HI = a, LO = all ones. No exception is raised.
- 0x80000000 / −1 (DIV): LO = 0x80000000, HI = 0 (wraps).
- `start` while `busy` is ignored. The pipeline guarantees this does not happen.
- MTHI/MTLO:
  - Accepted only when `busy` is low; ignored while busy.
  - If a write coincides with `start` in IDLE, the write applies at that edge. The operation's result overwrites it at FIX.
- `flush` in RUN or FIX: next state is IDLE. HI/LO are unchanged and `done` is not pulsed.

## Timing

- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state = IDLE, counter = 0.
- `start` is sampled at edge E0. `busy` is registered and is high from after E0 through E33.
- RUN covers edges E1–E32. The FIX commit happens at E33.
- `hi`/`lo` are valid after E33, giving a latency of 33 cycles. `busy` falls and `done` is high for the cycle after E33.
- A new `start` is accepted in the cycle after E33, so back-to-back throughput is 34 cycles per operation.
- MTHI/MTLO data is visible on `hi`/`lo` the cycle after the write edge.
- `rst` asserted mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration

- Macro: `MULDIV_FAST_MUL_EN`.
- Defined: MULT/MULTU complete combinationally with a single `*`.
  - The result commits at E0 and `busy` never rises.
  - `done` pulses in the cycle after E0.
  - DIV/DIVU are unchanged at 33 cycles.
- Undefined: all four ops use the iterative path with 33-cycle latency.

## Structure

- Shared package `mips_pkg` holds:
  - the `muldiv_op_t` enum;
  - the `muldiv_state_t` enum (IDLE, RUN, FIX);
  - the constant `MULDIV_STEPS = 32`.
- One natural sub-module, `muldiv_step`, is purely combinational. It takes {acc, q, b_mag, is_div} and returns the next {acc, q} for a single radix-2 step. The FSM, counter, sign fixup and HI/LO registers stay in `muldiv_unit`.

## Test plan

- MULTU a=7, b=6 → `busy` high for 33 cycles, then HI=0, LO=42, with a one-cycle `done`.
- MULT a=−3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 → HI=100, LO=0xFFFFFFFF. DIV a=0x80000000, b=−1 → LO=0x80000000, HI=0.
- MTHI 0x1234 in IDLE, then MULTU 2×3 with `flush` at cycle 10:
  - HI stays 0x1234 and LO stays 0;
  - `busy` is low the next cycle and `done` never asserts.
- `start` and MTLO while busy → both ignored and the original result commits at E33. `rst` pulsed at cycle 5 → HI=LO=0 and `busy`=0 immediately.
- With `MULDIV_FAST_MUL_EN`: MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE after one edge, and `busy` stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core's multiply/divide
// sequencer (muldiv_unit) and its combinational step datapath (muldiv_step).
//   muldiv_op_t    - operation select: MULT, MULTU, DIV, DIVU
//   muldiv_state_t - sequencer states: IDLE, RUN, FIX
//   MULDIV_STEPS   - radix-2 iterations per operation
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    localparam int unsigned MULDIV_STEPS = 32;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the multiply/divide datapath.
// Purely combinational.
//   acc_i   - upper working register (partial product high / partial remainder)
//   q_i     - lower working register (multiplier / dividend, shifting out)
//   b_mag_i - multiplicand or divisor magnitude
//   is_div_i- 1: restoring shift-subtract, 0: shift-add
//   acc_o, q_o - next {acc, q}
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_mag_i,
    input  logic             is_div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc_i} + {1'b0, b_mag_i};
        shl  = {acc_i, q_i[WIDTH-1]};
        diff = shl - {1'b0, b_mag_i};
        if (is_div_i) begin
            // acc < divisor always holds, so shl < 2*divisor: bit WIDTH of the
            // difference is exactly the borrow (shl < divisor).
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shl[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else if (q_i[0]) begin
            {acc_o, q_o} = {sum, q_i[WIDTH-1:1]};
        end else begin
            {acc_o, q_o} = {1'b0, acc_i, q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus
// MTHI/MTLO writes. Operations take 33 cycles from start to commit.
//   clk, rst        - clock, asynchronous active-high reset
//   start, op, a, b - launch an operation (a: rs, b: rt)
//   flush           - abort an in-flight operation without committing
//   hi_we, lo_we, wdata - MTHI/MTLO, accepted only while not busy
//   busy            - operation in flight
//   done            - one-cycle pulse after HI/LO commit
//   hi, lo          - HI/LO registers
// Macro MULDIV_FAST_MUL_EN: MULT/MULTU complete in a single cycle with a
// combinational multiplier; divides remain iterative.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t    state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, bmag_q, bmag_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             isdiv_q, isdiv_d, neg_q, neg_d, remneg_q, remneg_d;
    logic             div0_q, div0_d, done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, step_acc, step_q;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = op_is_signed(op) & a[WIDTH-1];
    assign b_neg = op_is_signed(op) & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign prod  = {acc_q, q_q};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag;
    assign fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i   (acc_q),
        .q_i     (q_q),
        .b_mag_i (bmag_q),
        .is_div_i(isdiv_q),
        .acc_o   (step_acc),
        .q_o     (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        bmag_d   = bmag_q;
        isdiv_d  = isdiv_q;
        neg_d    = neg_q;
        remneg_d = remneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !flush) begin
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[1]) begin
                        {hi_d, lo_d} = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
                        done_d       = 1'b1;
                    end else
`endif
                    begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        acc_d    = '0;
                        q_d      = a_mag;
                        bmag_d   = b_mag;
                        isdiv_d  = op[1];
                        neg_d    = a_neg ^ b_neg;
                        remneg_d = a_neg;
                        div0_d   = op[1] && (b == '0);
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    q_d   = step_q;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(MULDIV_STEPS - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (isdiv_q) begin
                        // Divide by zero leaves |a| in acc, so the dividend-sign
                        // fixup already yields HI = a; only LO needs forcing.
                        lo_d = div0_q ? '1 : (neg_q ? -q_q : q_q);
                        hi_d = remneg_q ? -acc_q : acc_q;
                    end else begin
                        {hi_d, lo_d} = neg_q ? -prod : prod;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            bmag_q   <= '0;
            isdiv_q  <= 1'b0;
            neg_q    <= 1'b0;
            remneg_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            bmag_q   <= bmag_d;
            isdiv_q  <= isdiv_d;
            neg_q    <= neg_d;
            remneg_q <= remneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit with hand-computed
// HI/LO results, latency, done pulse, flush, busy-time writes and async reset.
// Honours MULDIV_FAST_MUL_EN for multiply latency expectations.
module tb_muldiv_unit;
    import mips_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    muldiv_op_t  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .flush(flush),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Launch one op; optionally inject start+MTHI+MTLO during cycle inj (0 = none).
    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input int inj);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy_after_start"}, {63'd0, busy}, {63'd0, lat != 0});
        n = 0;
        while (busy && n < 100) begin
            if (n + 1 == inj) begin
                start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            n++;
            if (n == inj) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                check_eq({tag, "_hi_hold"}, {32'd0, hi}, {32'd0, exp_hi});
                check_eq({tag, "_lo_hold"}, {32'd0, lo}, {32'd0, exp_lo});
            end
        end
        check_eq({tag, "_latency"}, 64'(n), 64'(lat));
        check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
        check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        check_eq({tag, "_done_clear"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int  cyc;
        logic seen;
        muldiv_op_t fop;
        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = OP_MULT; a = '0; b = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;

        run_op("multu_7x6",   OP_MULTU, 32'd7,          32'd6,          32'd0,          32'd42,         MUL_LAT, 0);
        run_op("mult_m3x5",   OP_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  MUL_LAT, 0);
        run_op("multu_max2",  OP_MULTU, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE,  MUL_LAT, 0);
        run_op("mult_min2",   OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0,          MUL_LAT, 0);
        run_op("div_m7_2",    OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  DIV_LAT, 0);
        run_op("divu_by0",    OP_DIVU,  32'd100,        32'd0,          32'd100,        32'hFFFF_FFFF,  DIV_LAT, 0);
        run_op("div_m100_0",  OP_DIV,   32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C,  32'hFFFF_FFFF,  DIV_LAT, 0);
        run_op("div_ovf",     OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  DIV_LAT, 0);
        run_op("divu_max7",   OP_DIVU,  32'hFFFF_FFFF,  32'd7,          32'd3,          32'h2492_4924,  DIV_LAT, 0);
        run_op("busy_inject", OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         DIV_LAT, 5);

        // Asynchronous reset mid-operation, checked before any further edge.
        @(negedge clk);
        start = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_hi", {32'd0, hi}, 64'd0);
        check_eq("arst_lo", {32'd0, lo}, 64'd0);
        check_eq("arst_busy", {63'd0, busy}, 64'd0);
        check_eq("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;

        // MTHI in IDLE, then an iterative op aborted by flush.
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        check_eq("mthi_hi", {32'd0, hi}, 64'h1234);
        check_eq("mthi_lo", {32'd0, lo}, 64'd0);
`ifdef MULDIV_FAST_MUL_EN
        fop = OP_DIVU;
`else
        fop = OP_MULTU;
`endif
        start = 1'b1; op = fop; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) begin
            seen = seen | done;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            seen = seen | done;
            @(negedge clk);
        end
        check_eq("flush_no_done", {63'd0, seen}, 64'd0);
        check_eq("flush_hi", {32'd0, hi}, 64'h1234);
        check_eq("flush_lo", {32'd0, lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
